// File: rtl/window_gen.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// window_gen
// Takes one padded RGB row-triple (three rows per channel) and streams the
// 3x3 windows that can be formed from it, left to right, one per handshake.
// Window k holds pixels k..k+2 of each row; pixel data passes through untouched.
//
// Ports
//   clk                    sole clock, rising edge
//   reset                  asynchronous, active-low reset
//   row_valid / row_ready  row-triple handshake (ready only while idle)
//   {R,G,B}_row{0,1,2}     padded rows, pixel j at [j*DATA_W +: DATA_W]
//   win_valid / win_ready  window handshake
//   {R,G,B}_win            3x3 window, pixel (r,c) at [(r*3+c)*DATA_W +: DATA_W]
//   win_col                column index k of the presented window
//   win_last               presented window is the last of the triple
//   row_done               one-cycle pulse when the last window is accepted
//   frame_done             one-cycle pulse with the row_done of the last triple
// -----------------------------------------------------------------------------
module window_gen #(
   parameter int ROW_W    = 418,
   parameter int DATA_W   = 8,
   parameter int NUM_ROWS = 416
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       row_valid,
   output logic                       row_ready,
   input  logic [ROW_W*DATA_W-1:0]    R_row0,
   input  logic [ROW_W*DATA_W-1:0]    G_row0,
   input  logic [ROW_W*DATA_W-1:0]    B_row0,
   input  logic [ROW_W*DATA_W-1:0]    R_row1,
   input  logic [ROW_W*DATA_W-1:0]    G_row1,
   input  logic [ROW_W*DATA_W-1:0]    B_row1,
   input  logic [ROW_W*DATA_W-1:0]    R_row2,
   input  logic [ROW_W*DATA_W-1:0]    G_row2,
   input  logic [ROW_W*DATA_W-1:0]    B_row2,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [9*DATA_W-1:0]        R_win,
   output logic [9*DATA_W-1:0]        G_win,
   output logic [9*DATA_W-1:0]        B_win,
   output logic [$clog2(ROW_W)-1:0]   win_col,
   output logic                       win_last,
   output logic                       row_done,
   output logic                       frame_done
);

   localparam int COL_W = $clog2(ROW_W);
   localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int BUS_W = ROW_W * DATA_W;
   localparam int WIN_W = 9 * DATA_W;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_W - 3);
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(NUM_ROWS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
   typedef logic [2:0][BUS_W-1:0] rows_t;   // [row] -> padded row bus

   state_t             state_q;
   rows_t              r_rows_q, g_rows_q, b_rows_q;
   logic               row_ready_q, win_valid_q, win_last_q;
   logic               row_done_q, frame_done_q;
   logic [COL_W-1:0]   win_col_q, col_d;
   logic [CNT_W-1:0]   row_cnt_q;
   logic [WIN_W-1:0]   r_win_q, g_win_q, b_win_q;
   logic [WIN_W-1:0]   r_win_d, g_win_d, b_win_d;
   logic               accept, load_win;

   // Gather the 3x3 window whose left column is k from one channel.
   function automatic logic [WIN_W-1:0] window_at(input rows_t rows,
                                                  input logic [COL_W-1:0] k);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w[(r*3+c)*DATA_W +: DATA_W] = rows[r][(int'(k)+c)*DATA_W +: DATA_W];
         end
      end
      return w;
   endfunction

   assign accept = win_valid_q && win_ready;

   // A window is (re)loaded on the LOAD edge (k=0) and on every accepted
   // non-final window (k+1).
   assign load_win = (state_q == LOAD) ||
                     ((state_q == STREAM) && accept && !win_last_q);

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      col_d = '0;
      if ((state_q == STREAM) && !win_last_q) begin
         col_d = win_col_q + 1'b1;
      end
      r_win_d = window_at(r_rows_q, col_d);
      g_win_d = window_at(g_rows_q, col_d);
      b_win_d = window_at(b_rows_q, col_d);
   end

   // NOTE: the capture registers are large, but they are cleared on reset
   // like everything else so a fresh start never exposes stale pixels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         r_rows_q     <= '0;
         g_rows_q     <= '0;
         b_rows_q     <= '0;
         row_ready_q  <= 1'b0;
         win_valid_q  <= 1'b0;
         win_last_q   <= 1'b0;
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;
         win_col_q    <= '0;
         row_cnt_q    <= '0;
         r_win_q      <= '0;
         g_win_q      <= '0;
         b_win_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the pre-edge values of the others regardless of line order.
         row_done_q   <= 1'b0;
         frame_done_q <= 1'b0;

         if (load_win) begin
            win_col_q  <= col_d;
            win_last_q <= (col_d == LAST_COL);
            r_win_q    <= r_win_d;
            g_win_q    <= g_win_d;
            b_win_q    <= b_win_d;
         end

         unique case (state_q)
            IDLE: begin
               if (row_valid && row_ready_q) begin
                  r_rows_q    <= {R_row2, R_row1, R_row0};
                  g_rows_q    <= {G_row2, G_row1, G_row0};
                  b_rows_q    <= {B_row2, B_row1, B_row0};
                  row_ready_q <= 1'b0;
                  state_q     <= LOAD;
               end else begin
                  row_ready_q <= 1'b1;
               end
            end
            LOAD: begin
               win_valid_q <= 1'b1;
               state_q     <= STREAM;
            end
            STREAM: begin
               if (accept && win_last_q) begin
                  win_valid_q  <= 1'b0;
                  win_last_q   <= 1'b0;
                  row_done_q   <= 1'b1;
                  frame_done_q <= (row_cnt_q == LAST_ROW);
                  row_cnt_q    <= (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
                  row_ready_q  <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign row_ready  = row_ready_q;
   assign win_valid  = win_valid_q;
   assign win_last   = win_last_q;
   assign win_col    = win_col_q;
   assign row_done   = row_done_q;
   assign frame_done = frame_done_q;
   assign R_win      = r_win_q;
   assign G_win      = g_win_q;
   assign B_win      = b_win_q;

endmodule

// File: tb/tb_window_gen.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_window_gen
// Directed stimulus pushes the windows each row-triple must produce into a
// queue; an independent monitor pops and compares on every accepted window,
// checks that stalled windows hold steady, and counts row/frame pulses.
// -----------------------------------------------------------------------------
module tb_window_gen;

   localparam int ROW_W    = 418;
   localparam int DATA_W   = 8;
   localparam int NUM_ROWS = 4;
   localparam int NWIN     = ROW_W - 2;
   localparam int COL_W    = $clog2(ROW_W);
   localparam int BUS_W    = ROW_W * DATA_W;
   localparam int WIN_W    = 9 * DATA_W;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic row_valid = 1'b0;
   logic win_ready = 1'b1;
   logic row_ready, win_valid, win_last, row_done, frame_done;
   logic [BUS_W-1:0] R_row0, G_row0, B_row0, R_row1, G_row1, B_row1;
   logic [BUS_W-1:0] R_row2, G_row2, B_row2;
   logic [WIN_W-1:0] R_win, G_win, B_win;
   logic [COL_W-1:0] win_col;

   window_gen #(.ROW_W(ROW_W), .DATA_W(DATA_W), .NUM_ROWS(NUM_ROWS)) dut (
      .clk(clk), .reset(reset),
      .row_valid(row_valid), .row_ready(row_ready),
      .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
      .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
      .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
      .win_valid(win_valid), .win_ready(win_ready),
      .R_win(R_win), .G_win(G_win), .B_win(B_win),
      .win_col(win_col), .win_last(win_last),
      .row_done(row_done), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIN_W-1:0] r, g, b;
      int               col;
      logic             last;
   } win_t;

   win_t       exp_q[$];
   logic [7:0] pix [3][3][ROW_W];   // [channel][row][column]

   int n_checks = 0, n_fail = 0;
   int cyc = 0, acc_cnt = 0, first_acc = -1, last_acc = -1;
   int rd_cnt = 0, fd_cnt = 0, fd_at = 0;
   bit toggle_mode = 1'b0;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   function automatic logic [BUS_W-1:0] pack(input int ch, input int r);
      logic [BUS_W-1:0] b;
      for (int j = 0; j < ROW_W; j++) b[j*DATA_W +: DATA_W] = pix[ch][r][j];
      return b;
   endfunction

   // 0: ramp j+100r (+37 per channel), 1: different descending data,
   // 2: per-channel constants R=1, G=2, B=3.
   task automatic load_pattern(input int kind);
      for (int ch = 0; ch < 3; ch++)
         for (int r = 0; r < 3; r++)
            for (int j = 0; j < ROW_W; j++)
               case (kind)
                  0:       pix[ch][r][j] = 8'(j + 100*r + 37*ch);
                  1:       pix[ch][r][j] = 8'(255 - j - 7*r + 11*ch);
                  default: pix[ch][r][j] = 8'(ch + 1);
               endcase
      R_row0 = pack(0, 0); R_row1 = pack(0, 1); R_row2 = pack(0, 2);
      G_row0 = pack(1, 0); G_row1 = pack(1, 1); G_row2 = pack(1, 2);
      B_row0 = pack(2, 0); B_row1 = pack(2, 1); B_row2 = pack(2, 2);
   endtask

   task automatic push_expected();
      win_t e;
      for (int k = 0; k < NWIN; k++) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               e.r[(r*3+c)*DATA_W +: DATA_W] = pix[0][r][k+c];
               e.g[(r*3+c)*DATA_W +: DATA_W] = pix[1][r][k+c];
               e.b[(r*3+c)*DATA_W +: DATA_W] = pix[2][r][k+c];
            end
         e.col  = k;
         e.last = (k == NWIN - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic scramble_buses();
      R_row0 = ~R_row0; R_row1 = ~R_row1; R_row2 = ~R_row2;
      G_row0 = ~G_row0; G_row1 = ~G_row1; G_row2 = ~G_row2;
      B_row0 = ~B_row0; B_row1 = ~B_row1; B_row2 = ~B_row2;
   endtask

   // Called at posedge+1; the capture happens on the next edge.
   task automatic send_triple();
      check("row_ready_before_capture", row_ready, 1);
      row_valid = 1'b1;
      @(posedge clk); #1;
      row_valid = 1'b0;
      scramble_buses();
      check("row_ready_after_capture", row_ready, 0);
   endtask

   task automatic wait_row_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk); #1;
         if (row_done) seen = 1'b1;
      end
      check("row_done_within_budget", seen, 1);
   endtask

   task automatic settle();
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("row_ready_after_reset", row_ready, 1);
   endtask

   // ---------------- window_ready driver ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         if (toggle_mode) win_ready = ~win_ready;
         else             win_ready = 1'b1;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin : monitor
      win_t e;
      logic stall = 1'b0;
      logic [WIN_W-1:0] hr, hg, hb;
      logic [COL_W-1:0] hc;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("hold_valid", win_valid, 1);
               check("hold_R", R_win, hr);
               check("hold_G", G_win, hg);
               check("hold_B", B_win, hb);
               check("hold_col", win_col, hc);
            end
            stall = win_valid && !win_ready;
            hr = R_win; hg = G_win; hb = B_win; hc = win_col;
            if (win_valid && win_ready) begin
               check("window_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("win_R", R_win, e.r);
                  check("win_G", G_win, e.g);
                  check("win_B", B_win, e.b);
                  check("win_col", win_col, e.col);
                  check("win_last", win_last, e.last);
               end
               acc_cnt++;
               if (first_acc < 0) first_acc = cyc;
               last_acc = cyc;
            end
            if (row_done) rd_cnt++;
            if (frame_done) begin
               fd_cnt++;
               fd_at = rd_cnt;
               check("frame_done_with_row_done", row_done, 1);
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed tests ----------------
   initial begin : stimulus
      int rd0, fd0, acc0;
      bit found;
      R_row0 = '0; R_row1 = '0; R_row2 = '0;
      G_row0 = '0; G_row1 = '0; G_row2 = '0;
      B_row0 = '0; B_row1 = '0; B_row2 = '0;

      // Reset state
      repeat (3) @(posedge clk); #1;
      check("rst_row_ready", row_ready, 0);
      check("rst_win_valid", win_valid, 0);
      check("rst_win_last", win_last, 0);
      check("rst_row_done", row_done, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_win_col", win_col, 0);
      check("rst_R_win", R_win, 0);
      check("rst_G_win", G_win, 0);
      check("rst_B_win", B_win, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("row_ready_after_release", row_ready, 1);

      // Ramp triple, win_ready high: latency, k=0 window, back-to-back stream
      load_pattern(0);
      push_expected();
      rd0 = rd_cnt; acc0 = acc_cnt; first_acc = -1;
      send_triple();
      check("latency_first_edge_no_valid", win_valid, 0);
      @(posedge clk); #1;
      check("latency_second_edge_valid", win_valid, 1);
      check("k0_R_win", R_win, 72'hCAC9C8_666564_020100);
      check("k0_win_col", win_col, 0);
      wait_row_done(NWIN + 10);
      settle();
      check("t1_row_done_count", rd_cnt - rd0, 1);
      check("t1_window_count", acc_cnt - acc0, NWIN);
      check("t1_throughput_span", last_acc - first_acc, NWIN - 1);
      check("t1_queue_empty", exp_q.size(), 0);

      // Same triple, win_ready toggling every cycle
      load_pattern(0);
      push_expected();
      acc0 = acc_cnt; first_acc = -1;
      toggle_mode = 1'b1;
      send_triple();
      wait_row_done(2*NWIN + 20);
      toggle_mode = 1'b0;
      settle();
      check("t2_window_count", acc_cnt - acc0, NWIN);
      check("t2_cycles_for_all_windows", last_acc - first_acc + 1, 2*NWIN - 1);

      // Second row_valid mid-stream with different data is ignored
      load_pattern(0);
      push_expected();
      acc0 = acc_cnt; rd0 = rd_cnt;
      send_triple();
      repeat (50) begin @(posedge clk); #1; end
      load_pattern(1);
      row_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         check("t3_row_ready_low_midstream", row_ready, 0);
      end
      row_valid = 1'b0;
      wait_row_done(NWIN + 10);
      settle();
      check("t3_window_count", acc_cnt - acc0, NWIN);
      check("t3_row_done_count", rd_cnt - rd0, 1);

      // Reset at k=200 discards the triple
      load_pattern(0);
      push_expected();
      rd0 = rd_cnt;
      send_triple();
      found = 1'b0;
      for (int i = 0; i < NWIN + 10 && !found; i++) begin
         @(posedge clk); #1;
         if (win_valid && win_col == COL_W'(200)) found = 1'b1;
      end
      check("t4_reached_k200", found, 1);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("t4_async_win_valid", win_valid, 0);
      check("t4_async_win_col", win_col, 0);
      check("t4_async_R_win", R_win, 0);
      check("t4_async_G_win", G_win, 0);
      check("t4_async_B_win", B_win, 0);
      check("t4_async_row_ready", row_ready, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("t4_row_ready_after_release", row_ready, 1);
      check("t4_no_row_done", rd_cnt - rd0, 0);
      load_pattern(1);
      push_expected();
      acc0 = acc_cnt;
      send_triple();
      wait_row_done(NWIN + 10);
      settle();
      check("t4_new_triple_windows", acc_cnt - acc0, NWIN);

      // Frame: NUM_ROWS+1 triples back-to-back, frame_done only with NUM_ROWS-th
      do_reset();
      rd0 = rd_cnt; fd0 = fd_cnt;
      for (int t = 0; t <= NUM_ROWS; t++) begin
         load_pattern(t % 2);
         push_expected();
         send_triple();
         wait_row_done(NWIN + 10);
      end
      settle();
      check("t5_row_done_count", rd_cnt - rd0, NUM_ROWS + 1);
      check("t5_frame_done_count", fd_cnt - fd0, 1);
      check("t5_frame_done_position", fd_at - rd0, NUM_ROWS);

      // Per-channel constants: no cross-channel mixing
      load_pattern(2);
      push_expected();
      send_triple();
      @(posedge clk); #1;
      check("t6_R_const", R_win, {9{8'd1}});
      check("t6_G_const", G_win, {9{8'd2}});
      check("t6_B_const", B_win, {9{8'd3}});
      wait_row_done(NWIN + 10);
      settle();

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
